axis_oscilloscope_reader: RTL and testbench

- Playback side of the scope capture path: after capture completes, reads the circular sample BRAM starting at (trigger address − pre-trigger count) mod depth.
- Streams tot_data+1 samples in chronological order to an AXI4-Stream master with full backpressure and tlast on the final sample.
- Sits between the capture BRAM read port and the DMA/readout stream.

---
 rtl/axis_oscilloscope_reader.sv | 171 +++++++++++++++++
 tb/tb_axis_oscilloscope_reader.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_oscilloscope_reader.sv
// rtl/axis_oscilloscope_reader.sv - circular capture BRAM playback to an AXI4-Stream master
//
// Purpose:
//   After a capture, replays tot_data+1 samples from the ring buffer in
//   chronological order. The readout starts (trg_addr - pre_data) mod depth.
//   Reads are issued against a 1-cycle-latency BRAM port. Returned data lands
//   in a 2-entry skid FIFO whose head drives the stream, so throughput is one
//   beat per cycle and backpressure is fully honoured.
//
// Ports:
//   aclk, aresetn      clock, asynchronous active-low reset
//   start_flag         level start request, sampled only while idle
//   trg_addr           ring address of the trigger sample
//   pre_data           samples preceding the trigger
//   tot_data           transfer length minus one
//   sts_data           {accepted beat count, busy}
//   bram_porta_*       BRAM read port (always enabled, same clock)
//   m_axis_*           AXI4-Stream master

module axis_oscilloscope_reader #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 12
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        start_flag,
    input  logic [CNTR_WIDTH-1:0]       trg_addr,
    input  logic [CNTR_WIDTH-1:0]       pre_data,
    input  logic [CNTR_WIDTH-1:0]       tot_data,
    output logic [CNTR_WIDTH:0]         sts_data,
    output logic                        bram_porta_clk,
    output logic                        bram_porta_rst,
    output logic [CNTR_WIDTH-1:0]       bram_porta_addr,
    input  logic [AXIS_TDATA_WIDTH-1:0] bram_porta_rddata,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [CNTR_WIDTH-1:0]       rd_addr_q, rd_addr_d;
    logic [CNTR_WIDTH-1:0]       len_q, len_d;
    logic [CNTR_WIDTH-1:0]       issue_cnt_q, issue_cnt_d;
    logic [CNTR_WIDTH-1:0]       beat_cnt_q, beat_cnt_d;
    logic                        inflight_q, inflight_d;
    logic                        inflight_last_q, inflight_last_d;
    logic [1:0]                  occ_q, occ_d;
    logic                        wr_ptr_q, wr_ptr_d;
    logic                        rd_ptr_q, rd_ptr_d;
    logic [AXIS_TDATA_WIDTH-1:0] fifo_data_q [2];
    logic                        fifo_last_q [2];

    logic       pop;
    logic       issue;
    logic       busy;
    logic [2:0] level;

    assign bram_porta_clk  = aclk;
    assign bram_porta_rst  = ~aresetn;
    assign bram_porta_addr = rd_addr_q;

    assign m_axis_tvalid = (occ_q != 2'd0);
    assign m_axis_tdata  = fifo_data_q[rd_ptr_q];
    assign m_axis_tlast  = fifo_last_q[rd_ptr_q];

    assign pop  = m_axis_tvalid & m_axis_tready;
    assign busy = (state_q != S_IDLE);
    assign sts_data = {beat_cnt_q, busy};

    // FIFO level after this edge, counting the read already in flight. A new
    // read is only issued when it is guaranteed a free slot on arrival, which
    // bounds occ + inflight to 2 and makes overflow impossible.
    assign level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue = (state_q == S_READ) && (level < 3'd2);

    always_comb begin
        state_d         = state_q;
        rd_addr_d       = rd_addr_q;
        len_d           = len_q;
        issue_cnt_d     = issue_cnt_q;
        beat_cnt_d      = beat_cnt_q;
        occ_d           = level[1:0];
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        inflight_d      = issue;
        inflight_last_d = issue && (issue_cnt_q == len_q);

        if (inflight_q) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d   = ~rd_ptr_q;
            beat_cnt_d = beat_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_flag) begin
                    rd_addr_d   = trg_addr - pre_data;
                    len_d       = tot_data;
                    issue_cnt_d = '0;
                    beat_cnt_d  = '0;
                    state_d     = S_READ;
                end
            end
            S_READ: begin
                if (issue) begin
                    rd_addr_d = rd_addr_q + 1'b1;
                    if (issue_cnt_q == len_q) begin
                        state_d = S_DRAIN;
                    end else begin
                        issue_cnt_d = issue_cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // Leave as soon as the final handshake empties the FIFO so
                // busy drops on the edge that completes the last beat.
                if (level == 3'd0) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q         <= S_IDLE;
            rd_addr_q       <= '0;
            len_q           <= '0;
            issue_cnt_q     <= '0;
            beat_cnt_q      <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            occ_q           <= 2'd0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            state_q         <= state_d;
            rd_addr_q       <= rd_addr_d;
            len_q           <= len_d;
            issue_cnt_q     <= issue_cnt_d;
            beat_cnt_q      <= beat_cnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            occ_q           <= occ_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            // BRAM data for last cycle's address is valid now; park it.
            if (inflight_q) begin
                fifo_data_q[wr_ptr_q] <= bram_porta_rddata;
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
            end
        end
    end

endmodule

// File: tb/tb_axis_oscilloscope_reader.sv
// tb/tb_axis_oscilloscope_reader.sv - randomized self-checking bench for axis_oscilloscope_reader

module tb_axis_oscilloscope_reader;

    localparam int W     = 32;
    localparam int CW    = 12;
    localparam int DEPTH = 1 << CW;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          start_flag = 1'b0;
    logic [CW-1:0] trg_addr = '0;
    logic [CW-1:0] pre_data = '0;
    logic [CW-1:0] tot_data = '0;
    logic [CW:0]   sts_data;
    logic          bram_porta_clk;
    logic          bram_porta_rst;
    logic [CW-1:0] bram_porta_addr;
    logic [W-1:0]  bram_porta_rddata = '0;
    logic          m_axis_tready = 1'b0;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;

    axis_oscilloscope_reader #(.AXIS_TDATA_WIDTH(W), .CNTR_WIDTH(CW)) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .start_flag        (start_flag),
        .trg_addr          (trg_addr),
        .pre_data          (pre_data),
        .tot_data          (tot_data),
        .sts_data          (sts_data),
        .bram_porta_clk    (bram_porta_clk),
        .bram_porta_rst    (bram_porta_rst),
        .bram_porta_addr   (bram_porta_addr),
        .bram_porta_rddata (bram_porta_rddata),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tlast      (m_axis_tlast)
    );

    always #5 aclk = ~aclk;

    logic [W-1:0] mem [DEPTH];
    always @(posedge aclk) bram_porta_rddata <= mem[bram_porta_addr];

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] got_data [$];
    logic         got_last [$];
    int           got_cycle [$];
    int           busy_cycles, first_valid, stall_viol;
    logic         start_busy;
    bit           timed_out;
    logic         rst_tvalid;
    logic [CW:0]  rst_sts;
    logic [CW-1:0] rst_addr;

    // Reference: sample i of a readout is the ring word at (trg - pre + i) mod depth.
    function automatic logic [W-1:0] model_sample(input int trg, input int pre, input int i);
        return mem[(trg - pre + i + 2 * DEPTH) % DEPTH];
    endfunction

    // Starts a readout, then observes the stream until busy drops. Called and
    // returns in the slot 1 time unit after a rising edge.
    task automatic do_readout(input int trg, input int pre, input int tot, input int ready_mode,
                              input bit hold, input bit repulse, input int abort_beat);
        bit           prev_stall;
        logic [W-1:0] prev_data;
        logic         prev_last;
        int           cyc;
        got_data.delete();
        got_last.delete();
        got_cycle.delete();
        trg_addr = CW'(trg);
        pre_data = CW'(pre);
        tot_data = CW'(tot);
        start_flag = 1'b1;
        m_axis_tready = 1'b0;
        @(posedge aclk); #1;
        start_flag = hold;
        start_busy = sts_data[0];
        cyc = 0; busy_cycles = 0; first_valid = -1; stall_viol = 0;
        prev_stall = 0; prev_data = '0; prev_last = 1'b0; timed_out = 0;
        forever begin
            if (!sts_data[0]) break;
            if (cyc >= 20000) begin
                timed_out = 1;
                break;
            end
            busy_cycles++;
            trg_addr = CW'($urandom);
            pre_data = CW'($urandom);
            tot_data = CW'($urandom);
            if (repulse) start_flag = (cyc == 4);
            case (ready_mode)
                0: m_axis_tready = 1'b1;
                1: m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = ($urandom_range(0, 3) == 0);
            endcase
            if (prev_stall && !(m_axis_tvalid && m_axis_tdata === prev_data && m_axis_tlast === prev_last))
                stall_viol++;
            if (m_axis_tvalid && first_valid < 0) first_valid = cyc;
            if (abort_beat >= 0 && got_data.size() == abort_beat) begin
                aresetn = 1'b0;
                #1;
                rst_tvalid = m_axis_tvalid;
                rst_sts    = sts_data;
                rst_addr   = bram_porta_addr;
                @(posedge aclk); #1;
                aresetn = 1'b1;
                m_axis_tready = 1'b0;
                return;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                got_data.push_back(m_axis_tdata);
                got_last.push_back(m_axis_tlast);
                got_cycle.push_back(cyc);
            end
            @(posedge aclk); #1;
            cyc++;
        end
        m_axis_tready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge aclk);
        #1;
        vectors++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_stream: tvalid=%b tlast=%b required 0 0", m_axis_tvalid, m_axis_tlast);
        end
        vectors++;
        if (sts_data !== '0 || bram_porta_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_state: sts=%h addr=%h required 0 0", sts_data, bram_porta_addr);
        end
        vectors++;
        if (bram_porta_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_bram_rst: got %b required 1", bram_porta_rst);
        end
        aresetn = 1'b1;
        @(posedge aclk); #1;
    endtask

    task automatic test_basic();
        do_readout(100, 10, 19, 0, 0, 0, -1);
        vectors++;
        if (timed_out || got_data.size() != 20) begin
            miscompares++;
            $display("FAIL basic_count: got %0d beats (timeout=%0d) required 20", got_data.size(), timed_out);
        end
        for (int i = 0; i < got_data.size() && i < 20; i++) begin
            vectors++;
            if (got_data[i] !== model_sample(100, 10, i) || got_last[i] !== (i == 19) || got_cycle[i] != 2 + i) begin
                miscompares++;
                $display("FAIL basic_beat%0d: data=%h last=%b cyc=%0d required %h %b %0d",
                         i, got_data[i], got_last[i], got_cycle[i], model_sample(100, 10, i), (i == 19), 2 + i);
            end
        end
        vectors++;
        if (first_valid != 2 || busy_cycles != 22) begin
            miscompares++;
            $display("FAIL basic_timing: first_valid=%0d busy=%0d required 2 22", first_valid, busy_cycles);
        end
        vectors++;
        if (sts_data !== {12'd20, 1'b0}) begin
            miscompares++;
            $display("FAIL basic_sts: got %h required %h", sts_data, {12'd20, 1'b0});
        end
    endtask

    task automatic test_wrap();
        do_readout(5, 10, 15, 0, 0, 0, -1);
        vectors++;
        if (timed_out || got_data.size() != 16) begin
            miscompares++;
            $display("FAIL wrap_count: got %0d beats required 16", got_data.size());
        end
        for (int i = 0; i < got_data.size() && i < 16; i++) begin
            vectors++;
            if (got_data[i] !== mem[(4091 + i) % DEPTH] || got_last[i] !== (i == 15)) begin
                miscompares++;
                $display("FAIL wrap_beat%0d: data=%h last=%b required %h %b",
                         i, got_data[i], got_last[i], mem[(4091 + i) % DEPTH], (i == 15));
            end
        end
    endtask

    task automatic test_backpressure();
        do_readout(100, 10, 19, 1, 0, 0, -1);
        vectors++;
        if (timed_out || got_data.size() != 20 || stall_viol != 0) begin
            miscompares++;
            $display("FAIL bp_count: beats=%0d stall_viol=%0d required 20 0", got_data.size(), stall_viol);
        end
        for (int i = 0; i < got_data.size() && i < 20; i++) begin
            vectors++;
            if (got_data[i] !== model_sample(100, 10, i) || got_last[i] !== (i == 19)) begin
                miscompares++;
                $display("FAIL bp_beat%0d: data=%h last=%b required %h %b",
                         i, got_data[i], got_last[i], model_sample(100, 10, i), (i == 19));
            end
        end
    endtask

    task automatic test_single();
        do_readout(0, 0, 0, 0, 0, 0, -1);
        vectors++;
        if (got_data.size() != 1 || busy_cycles != 3) begin
            miscompares++;
            $display("FAIL single_count: beats=%0d busy=%0d required 1 3", got_data.size(), busy_cycles);
        end
        if (got_data.size() > 0) begin
            vectors++;
            if (got_data[0] !== mem[0] || got_last[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL single_beat: data=%h last=%b required %h 1", got_data[0], got_last[0], mem[0]);
            end
        end
    endtask

    task automatic test_start_flag();
        do_readout(200, 3, 19, 1, 0, 1, -1);
        vectors++;
        if (got_data.size() != 20 || stall_viol != 0) begin
            miscompares++;
            $display("FAIL repulse_count: beats=%0d stall_viol=%0d required 20 0", got_data.size(), stall_viol);
        end
        for (int i = 0; i < got_data.size() && i < 20; i++) begin
            vectors++;
            if (got_data[i] !== model_sample(200, 3, i) || got_last[i] !== (i == 19)) begin
                miscompares++;
                $display("FAIL repulse_beat%0d: data=%h required %h", i, got_data[i], model_sample(200, 3, i));
            end
        end
        @(posedge aclk); #1;
        vectors++;
        if (sts_data[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL repulse_idle: busy=%b required 0", sts_data[0]);
        end
        do_readout(300, 20, 9, 0, 1, 0, -1);
        do_readout(300, 20, 9, 0, 0, 0, -1);
        vectors++;
        if (start_busy !== 1'b1 || first_valid != 2 || got_data.size() != 10) begin
            miscompares++;
            $display("FAIL hold_restart: busy=%b first_valid=%0d beats=%0d required 1 2 10",
                     start_busy, first_valid, got_data.size());
        end
        for (int i = 0; i < got_data.size() && i < 10; i++) begin
            vectors++;
            if (got_data[i] !== model_sample(300, 20, i) || got_last[i] !== (i == 9)) begin
                miscompares++;
                $display("FAIL hold_beat%0d: data=%h required %h", i, got_data[i], model_sample(300, 20, i));
            end
        end
    endtask

    task automatic test_reset_midflight();
        do_readout(100, 10, 19, 0, 0, 0, 7);
        vectors++;
        if (rst_tvalid !== 1'b0 || rst_sts !== '0 || rst_addr !== '0) begin
            miscompares++;
            $display("FAIL midreset: tvalid=%b sts=%h addr=%h required 0 0 0", rst_tvalid, rst_sts, rst_addr);
        end
        do_readout(100, 10, 19, 0, 0, 0, -1);
        vectors++;
        if (got_data.size() != 20 || sts_data !== {12'd20, 1'b0}) begin
            miscompares++;
            $display("FAIL midreset_after: beats=%0d sts=%h required 20 %h", got_data.size(), sts_data, {12'd20, 1'b0});
        end
        for (int i = 0; i < got_data.size() && i < 20; i++) begin
            vectors++;
            if (got_data[i] !== model_sample(100, 10, i) || got_last[i] !== (i == 19)) begin
                miscompares++;
                $display("FAIL midreset_beat%0d: data=%h required %h", i, got_data[i], model_sample(100, 10, i));
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int trg, pre, tot, mode;
            trg  = $urandom_range(0, DEPTH - 1);
            pre  = $urandom_range(0, DEPTH - 1);
            tot  = $urandom_range(0, 40);
            mode = $urandom_range(1, 2);
            do_readout(trg, pre, tot, mode, 0, 0, -1);
            vectors++;
            if (timed_out || got_data.size() != tot + 1 || stall_viol != 0 || sts_data !== {CW'(tot + 1), 1'b0}) begin
                miscompares++;
                $display("FAIL random%0d_count: beats=%0d stall_viol=%0d sts=%h required %0d 0 %h",
                         r, got_data.size(), stall_viol, sts_data, tot + 1, {CW'(tot + 1), 1'b0});
            end
            for (int i = 0; i < got_data.size() && i <= tot; i++) begin
                vectors++;
                if (got_data[i] !== model_sample(trg, pre, i) || got_last[i] !== (i == tot)) begin
                    miscompares++;
                    $display("FAIL random%0d_beat%0d: data=%h last=%b required %h %b",
                             r, i, got_data[i], got_last[i], model_sample(trg, pre, i), (i == tot));
                end
            end
        end
    endtask

    task automatic test_full_ring();
        int trg, pre;
        trg = $urandom_range(0, DEPTH - 1);
        pre = $urandom_range(0, DEPTH - 1);
        do_readout(trg, pre, DEPTH - 1, 0, 0, 0, -1);
        vectors++;
        if (timed_out || got_data.size() != DEPTH || sts_data !== '0) begin
            miscompares++;
            $display("FAIL ring_count: beats=%0d sts=%h required %0d 0", got_data.size(), sts_data, DEPTH);
        end
        for (int i = 0; i < got_data.size() && i < DEPTH; i++) begin
            vectors++;
            if (got_data[i] !== model_sample(trg, pre, i) || got_last[i] !== (i == DEPTH - 1)) begin
                miscompares++;
                $display("FAIL ring_beat%0d: data=%h last=%b required %h %b",
                         i, got_data[i], got_last[i], model_sample(trg, pre, i), (i == DEPTH - 1));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_single();
        test_start_flag();
        test_reset_midflight();
        test_random();
        test_full_ring();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
